// File: rtl/imm_encoder_if.sv
// imm_encoder_if: word handshake, encoded output and error-count bundle.
// master drives words in; slave is the encoder.
interface imm_encoder_if #(
   parameter int ERR_CNT_W = 8
);
   logic                 in_valid;
   logic                 in_ready;
   logic [31:0]          in_instr;
   logic [31:0]          in_imm;
   logic [1:0]           in_imm_src;
   logic                 out_valid;
   logic                 out_ready;
   logic [31:0]          out_instr;
   logic                 out_err;
   logic [ERR_CNT_W-1:0] err_cnt;
   logic                 err_clr;

   modport master (
      output in_valid, in_instr, in_imm, in_imm_src,
      output out_ready, err_clr,
      input  in_ready, out_valid, out_instr, out_err, err_cnt
   );

   modport slave (
      input  in_valid, in_instr, in_imm, in_imm_src,
      input  out_ready, err_clr,
      output in_ready, out_valid, out_instr, out_err, err_cnt
   );
endinterface

// File: rtl/imm_encoder.sv
// imm_encoder: scatter an immediate into an I/U/B/J word, flag overflow.
// Define IMM_ROUNDTRIP_CHECK_EN to re-decode stage 2 and cross-check.
module imm_encoder #(
   parameter int ERR_CNT_W = 8
) (
   input logic          clk,
   input logic          rst_n,
   imm_encoder_if.slave bus
);
   typedef enum logic [1:0] {
      FMT_I = 2'b00,
      FMT_U = 2'b01,
      FMT_B = 2'b10,
      FMT_J = 2'b11
   } fmt_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] imm;
      fmt_t        fmt;
   } s1_t;

   logic                 rdy_en;
   logic                 s1_valid;
   s1_t                  s1;
   logic                 s2_valid;
   logic [31:0]          s2_instr;
   logic                 s2_err;
   logic                 s2_load;
   logic [31:0]          enc;
   logic                 rerr;
   logic [ERR_CNT_W-1:0] cnt;

   assign s2_load      = !s2_valid || bus.out_ready;
   assign bus.in_ready = rdy_en && (!s1_valid || s2_load);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en   <= 1'b0;
         s1_valid <= 1'b0;
         s1       <= '0;
      end else begin
         rdy_en <= 1'b1;
         if (bus.in_ready)
            s1_valid <= bus.in_valid;
         if (bus.in_valid && bus.in_ready)
            s1 <= '{bus.in_instr, bus.in_imm,
                    fmt_t'(bus.in_imm_src)};
      end
   end

   always_comb begin
      enc  = s1.instr;
      rerr = 1'b0;
      unique case (s1.fmt)
         FMT_I: begin
            enc[31:20] = s1.imm[11:0];
            rerr = s1.imm[31:11] != {21{s1.imm[11]}};
         end
         FMT_U: begin
            enc[31:12] = s1.imm[31:12];
            rerr = |s1.imm[11:0];
         end
         FMT_B: begin
            enc[31]    = s1.imm[12];
            enc[30:25] = s1.imm[10:5];
            enc[11:8]  = s1.imm[4:1];
            enc[7]     = s1.imm[11];
            rerr = s1.imm[0] ||
                   (s1.imm[31:12] != {20{s1.imm[12]}});
         end
         FMT_J: begin
            enc[31]    = s1.imm[20];
            enc[30:21] = s1.imm[10:1];
            enc[20]    = s1.imm[11];
            enc[19:12] = s1.imm[19:12];
            rerr = s1.imm[0] ||
                   (s1.imm[31:20] != {12{s1.imm[20]}});
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_instr <= '0;
         s2_err   <= 1'b0;
      end else if (s2_load) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_instr <= enc;
            s2_err   <= rerr;
         end
      end
   end

   assign bus.out_valid = s2_valid;
   assign bus.out_instr = s2_instr;

`ifdef IMM_ROUNDTRIP_CHECK_EN
   logic [31:0] s2_imm;
   fmt_t        s2_fmt;
   logic [31:0] dec;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_imm <= '0;
         s2_fmt <= FMT_I;
      end else if (s2_load && s1_valid) begin
         s2_imm <= s1.imm;
         s2_fmt <= s1.fmt;
      end
   end

   // Decode with the core's sign-extension rules
   always_comb begin
      dec = '0;
      unique case (s2_fmt)
         FMT_I: dec = {{20{s2_instr[31]}}, s2_instr[31:20]};
         FMT_U: dec = {s2_instr[31:12], 12'b0};
         FMT_B: dec = {{19{s2_instr[31]}}, s2_instr[31],
                       s2_instr[7], s2_instr[30:25],
                       s2_instr[11:8], 1'b0};
         FMT_J: dec = {{11{s2_instr[31]}}, s2_instr[31],
                       s2_instr[19:12], s2_instr[20],
                       s2_instr[30:21], 1'b0};
      endcase
   end

   assign bus.out_err = s2_err || (dec != s2_imm);
`else
   assign bus.out_err = s2_err;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         cnt <= '0;
      else if (bus.err_clr)
         cnt <= '0;
      else if (bus.out_valid && bus.out_ready &&
               bus.out_err && cnt != '1)
         cnt <= cnt + 1'b1;
   end

   assign bus.err_cnt = cnt;
endmodule

// File: tb/tb_imm_encoder.sv
// tb_imm_encoder: vector table, random scoreboard run, stall,
// saturation and mid-stream reset sequences.
module tb_imm_encoder;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   imm_encoder_if #(.ERR_CNT_W(8)) bus ();
   imm_encoder_if #(.ERR_CNT_W(2)) bus2 ();

   imm_encoder #(.ERR_CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus.slave));
   imm_encoder #(.ERR_CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   typedef struct {
      logic [31:0] instr;
      logic        err;
   } exp_t;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] imm;
      logic [1:0]  src;
      logic [31:0] e_instr;
      logic        e_err;
   } vec_t;

   int   checks = 0;
   int   failures = 0;
   int   cnt_model = 0;
   exp_t sb[$];

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", n, a, e);
      end
   endtask

   // Reference: field table copy plus signed-range arithmetic
   function automatic exp_t ref_enc(logic [31:0] instr,
                                    logic [31:0] imm,
                                    logic [1:0] src);
      exp_t r;
      int   fld[4][3];
      int   nf;
      int   s;
      s = imm;
      r.instr = instr;
      nf = 0;
      case (src)
         2'd0: begin
            nf = 1; fld[0] = '{31, 20, 0};
            r.err = !(s >= -2048 && s <= 2047);
         end
         2'd1: begin
            nf = 1; fld[0] = '{31, 12, 12};
            r.err = (imm % 4096) != 0;
         end
         2'd2: begin
            nf = 4;
            fld[0] = '{31, 31, 12}; fld[1] = '{30, 25, 5};
            fld[2] = '{11, 8, 1};   fld[3] = '{7, 7, 11};
            r.err = imm[0] || !(s >= -4096 && s <= 4095);
         end
         default: begin
            nf = 4;
            fld[0] = '{31, 31, 20}; fld[1] = '{30, 21, 1};
            fld[2] = '{20, 20, 11}; fld[3] = '{19, 12, 12};
            r.err = imm[0] || !(s >= -1048576 && s <= 1048575);
         end
      endcase
      for (int f = 0; f < nf; f++)
         for (int b = fld[f][1]; b <= fld[f][0]; b++)
            r.instr[b] = imm[fld[f][2] + b - fld[f][1]];
      return r;
   endfunction

   function automatic logic [31:0] rand_imm();
      case ($urandom_range(0, 4))
         0: return $urandom;
         1: return 32'($urandom_range(0, 8191)) - 32'd4096;
         2: return $urandom << 12;
         3: return 32'($urandom_range(0, 4194303)) - 32'd2097152;
         default: return 32'($urandom_range(0, 3)) - 32'd2;
      endcase
   endfunction

   // Called just after inputs are driven for a cycle
   task automatic sample();
      exp_t e;
      logic hs_err;
      #1;
      chk("err_cnt", 32'(bus.err_cnt), 32'(cnt_model));
      hs_err = 1'b0;
      if (bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL spurious_out actual=%h required=none",
                     bus.out_instr);
         end else begin
            e = sb.pop_front();
            chk("out_instr", bus.out_instr, e.instr);
            chk("out_err", 32'(bus.out_err), 32'(e.err));
            hs_err = e.err;
         end
      end
      if (bus.in_valid && bus.in_ready)
         sb.push_back(ref_enc(bus.in_instr, bus.in_imm,
                              bus.in_imm_src));
      if (bus.err_clr)
         cnt_model = 0;
      else if (hs_err && cnt_model < 255)
         cnt_model++;
   endtask

   vec_t        tv[10];
   int          ecnt;
   int          k;
   int          got;
   logic [31:0] held;
   logic [31:0] bpw[4];

   initial begin
      tv[0] = '{32'h13, 32'hFFFFFFFF, 2'd0, 32'hFFF00013, 1'b0};
      tv[1] = '{32'h63, 32'h00000010, 2'd2, 32'h00000863, 1'b0};
      tv[2] = '{32'h6F, 32'hFFFFFFFE, 2'd3, 32'hFFFFF06F, 1'b0};
      tv[3] = '{32'h13, 32'h00000800, 2'd0, 32'h80000013, 1'b1};
      tv[4] = '{32'h37, 32'h12345678, 2'd1, 32'h12345037, 1'b1};
      tv[5] = '{32'h37, 32'hABCDE000, 2'd1, 32'hABCDE037, 1'b0};
      tv[6] = '{32'h63, 32'hFFFFF000, 2'd2, 32'h80000063, 1'b0};
      tv[7] = '{32'h63, 32'h00000001, 2'd2, 32'h00000063, 1'b1};
      tv[8] = '{32'h6F, 32'h00100000, 2'd3, 32'h8000006F, 1'b1};
      tv[9] = '{32'h13, 32'hFFFFF800, 2'd0, 32'h80000013, 1'b0};

      bus.in_valid = 0; bus.in_instr = 0; bus.in_imm = 0;
      bus.in_imm_src = 0; bus.out_ready = 1; bus.err_clr = 0;
      bus2.in_valid = 0; bus2.in_instr = 0; bus2.in_imm = 0;
      bus2.in_imm_src = 0; bus2.out_ready = 1; bus2.err_clr = 0;

      repeat (2) @(negedge clk);
      #1;
      chk("rst_out_valid", 32'(bus.out_valid), 0);
      chk("rst_out_instr", bus.out_instr, 0);
      chk("rst_out_err", 32'(bus.out_err), 0);
      chk("rst_err_cnt", 32'(bus.err_cnt), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 1);

      ecnt = 0;
      foreach (tv[i]) begin
         @(negedge clk);
         bus.in_valid = 1; bus.in_instr = tv[i].instr;
         bus.in_imm = tv[i].imm; bus.in_imm_src = tv[i].src;
         #1;
         chk("vec_accept", 32'(bus.in_ready), 1);
         @(negedge clk);
         bus.in_valid = 0;
         #1;
         chk("vec_lat1", 32'(bus.out_valid), 0);
         @(negedge clk);
         #1;
         chk("vec_lat2", 32'(bus.out_valid), 1);
         chk("vec_instr", bus.out_instr, tv[i].e_instr);
         chk("vec_err", 32'(bus.out_err), 32'(tv[i].e_err));
         if (tv[i].e_err) ecnt++;
         @(negedge clk);
         #1;
         chk("vec_err_cnt", 32'(bus.err_cnt), 32'(ecnt));
      end
      cnt_model = ecnt;

      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         bus.in_valid = ($urandom_range(0, 9) < 7);
         bus.in_instr = $urandom;
         bus.in_imm = rand_imm();
         bus.in_imm_src = 2'($urandom_range(0, 3));
         bus.out_ready = ($urandom_range(0, 9) < 6);
         bus.err_clr = ($urandom_range(0, 39) == 0);
         sample();
      end
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus.in_valid = 0; bus.out_ready = 1; bus.err_clr = 0;
         sample();
      end
      chk("rand_drain", 32'(sb.size()), 0);

      bpw[0] = 32'h00000013; bpw[1] = 32'h00000037;
      bpw[2] = 32'h00000063; bpw[3] = 32'h0000006F;
      k = 0;
      got = 0;
      held = '0;
      for (int c = 0; c < 30 && (k < 4 || sb.size() != 0); c++) begin
         @(negedge clk);
         bus.in_valid = (k < 4);
         bus.in_instr = bpw[k % 4];
         bus.in_imm = 32'h00000120 + 32'(k) * 32'h40;
         bus.in_imm_src = 2'(k);
         bus.out_ready = (c >= 5);
         if (bus.in_valid) begin
            #1;
            if (bus.in_ready) k++;
            #0;
         end
         sample();
         if (c >= 2 && c < 5) begin
            chk("bp_in_ready", 32'(bus.in_ready), 0);
            chk("bp_out_valid", 32'(bus.out_valid), 1);
            if (c == 2) held = bus.out_instr;
            else chk("bp_hold", bus.out_instr, held);
         end
         if (bus.out_valid && bus.out_ready) got++;
      end
      chk("bp_accepted", 32'(k), 4);
      chk("bp_delivered", 32'(got), 4);

      bus2.in_instr = 32'h13; bus2.in_imm = 32'h800;
      bus2.in_imm_src = 2'd0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         bus2.in_valid = (c < 5);
      end
      @(negedge clk);
      #1;
      chk("sat_err_cnt", 32'(bus2.err_cnt), 3);
      bus2.err_clr = 1;
      @(negedge clk);
      bus2.err_clr = 0;
      #1;
      chk("clr_err_cnt", 32'(bus2.err_cnt), 0);
      bus2.in_valid = 1;
      @(negedge clk);
      bus2.in_valid = 0;
      @(negedge clk);
      bus2.err_clr = 1;
      #1;
      chk("clr_hs_valid", 32'(bus2.out_valid), 1);
      @(negedge clk);
      bus2.err_clr = 0;
      #1;
      chk("clr_wins", 32'(bus2.err_cnt), 0);
      bus2.in_valid = 1;
      @(negedge clk);
      bus2.in_valid = 0;
      repeat (2) @(negedge clk);
      #1;
      chk("post_clr_count", 32'(bus2.err_cnt), 1);

      bus.err_clr = 0;
      bus.out_ready = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         bus.in_valid = 1;
         bus.in_instr = 32'h13; bus.in_imm = 32'h800;
         bus.in_imm_src = 2'd0;
      end
      bus.out_ready = 1;
      @(negedge clk);
      #1;
      chk("pre_rst_valid", 32'(bus.out_valid), 1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 32'(bus.out_valid), 0);
      chk("mid_rst_instr", bus.out_instr, 0);
      chk("mid_rst_err_cnt", 32'(bus.err_cnt), 0);
      chk("mid_rst_err_cnt2", 32'(bus2.err_cnt), 0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 0);
      sb.delete();
      cnt_model = 0;
      bus.in_valid = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      #1;
      chk("post_rst_ready", 32'(bus.in_ready), 1);
      chk("post_rst_valid", 32'(bus.out_valid), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
